// File: rtl/fee_dtc_pkg.sv
// Shared FEE data-path definitions: default line patterns, pop-stage select
// encoding and small elaboration/arithmetic helpers.
package fee_dtc_pkg;

    localparam logic IDLE_BIT_DEF   = 1'b0;
    localparam logic TRAIN_RISE_BIT = 1'b1;
    localparam logic TRAIN_FALL_BIT = 1'b0;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_DATA,
        SEL_TRAIN,
        SEL_UNDERRUN
    } pop_sel_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Saturating increment for counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/ddr_pair_fifo.sv
// Synchronous FIFO of rise/fall word pairs; head is read combinationally so the
// pop stage can register it on the same edge that advances the read pointer.
module ddr_pair_fifo
    import fee_dtc_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   fill
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers are AW bits wide, so DEPTH being a power of 2 gives free wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (fill == (AW+1)'(DEPTH));
    assign empty = (fill == '0);

endmodule

// File: rtl/ddr_lane_serializer.sv
// Multi-lane DDR output serializer: buffered word pairs, idle/training pattern
// insertion, underrun accounting, rise bit in clkin-high and fall bit in clkin-low.
module ddr_lane_serializer
    import fee_dtc_pkg::*;
#(
    parameter int               LANES     = 8,
    parameter int               DEPTH     = 8,
    parameter logic [LANES-1:0] IDLE_RISE = {LANES{IDLE_BIT_DEF}},
    parameter logic [LANES-1:0] IDLE_FALL = {LANES{IDLE_BIT_DEF}},
    parameter int               CNT_W     = 16
) (
    input  logic                  clkin,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  train,
    input  logic [LANES-1:0]      din_rise,
    input  logic [LANES-1:0]      din_fall,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [LANES-1:0]      dout,
    output logic [clog2(DEPTH):0] fill,
    output logic                  underrun,
    output logic [CNT_W-1:0]      underrun_cnt
);

    logic [1:0]         rst_sync;
    logic               rst_n;
    pop_sel_e           sel;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [2*LANES-1:0] head;
    logic [LANES-1:0]   rise_q;
    logic [LANES-1:0]   fall_q;
    logic [LANES-1:0]   fall_qn;
    logic               pflag;
    logic               nflag;

    // Assert asynchronously, release two posedges later.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign din_ready = rst_n & ~full;
    assign push      = din_valid & din_ready;
    assign pop       = (sel == SEL_DATA);

    ddr_pair_fifo #(
        .W     (2*LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clkin),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({din_rise, din_fall}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .fill      (fill)
    );

    always_comb begin
        sel = SEL_IDLE;
        if (train)       sel = SEL_TRAIN;
        else if (enable) sel = empty ? SEL_UNDERRUN : SEL_DATA;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            rise_q       <= '0;
            fall_q       <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            pflag        <= 1'b0;
        end else begin
            pflag    <= ~pflag;
            underrun <= (sel == SEL_UNDERRUN);
            if (sel == SEL_UNDERRUN)
                underrun_cnt <= CNT_W'(sat_inc(32'(underrun_cnt), CNT_W));
            case (sel)
                SEL_TRAIN: begin
                    rise_q <= {LANES{TRAIN_RISE_BIT}};
                    fall_q <= {LANES{TRAIN_FALL_BIT}};
                end
                SEL_DATA: {rise_q, fall_q} <= head;
                default: begin
                    rise_q <= IDLE_RISE;
                    fall_q <= IDLE_FALL;
                end
            endcase
        end
    end

    // nflag follows pflag rather than free-toggling, so the phase pair cannot
    // come out of reset misaligned when release lands between clock edges.
    always_ff @(negedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            nflag   <= 1'b0;
            fall_qn <= '0;
        end else begin
            nflag   <= pflag;
            fall_qn <= fall_q;
        end
    end

    assign dout = (pflag ^ nflag) ? rise_q : fall_qn;

endmodule

// File: tb/tb_ddr_lane_serializer.sv
// Directed bench for ddr_lane_serializer: reset, streaming, full FIFO, training,
// counter saturation (second instance with CNT_W=4) and mid-stream reset.
module tb_ddr_lane_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       train = 1'b0;
    logic [7:0] din_rise = 8'h00;
    logic [7:0] din_fall = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [7:0] dout;
    logic [3:0] fill;
    logic       underrun;
    logic [15:0] underrun_cnt;

    logic       sat_en = 1'b1;
    logic       sat_off = 1'b0;
    logic [7:0] sat_zero = 8'h00;
    logic       sat_ready;
    logic [7:0] sat_dout;
    logic [3:0] sat_fill;
    logic       sat_unr;
    logic [3:0] sat_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ddr_lane_serializer #(.LANES(8), .DEPTH(8), .CNT_W(16)) u_dut (
        .clkin(clk), .reset_n(reset_n), .enable(enable), .train(train),
        .din_rise(din_rise), .din_fall(din_fall), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .fill(fill),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    ddr_lane_serializer #(.LANES(8), .DEPTH(8), .CNT_W(4)) u_sat (
        .clkin(clk), .reset_n(reset_n), .enable(sat_en), .train(sat_off),
        .din_rise(sat_zero), .din_fall(sat_zero), .din_valid(sat_off),
        .din_ready(sat_ready), .dout(sat_dout), .fill(sat_fill),
        .underrun(sat_unr), .underrun_cnt(sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] f);
        @(negedge clk);
        din_rise  = r;
        din_fall  = f;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    // One full clkin period: rise half after posedge, fall half after negedge.
    task automatic phase(input string tag, input logic [7:0] r, input logic [7:0] f, input logic u);
        @(posedge clk);
        #2;
        chk({tag, "_rise"}, dout, r);
        chk({tag, "_unr"}, underrun, u);
        @(negedge clk);
        #2;
        chk({tag, "_fall"}, dout, f);
    endtask

    initial begin
        logic [7:0] w;
        // 1: reset held with valid asserted
        #1 reset_n = 1'b0;
        din_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_dout", dout, 8'h00);
        chk("rst_ready", din_ready, 1'b0);
        chk("rst_fill", fill, 4'd0);
        chk("rst_cnt", underrun_cnt, 16'd0);
        chk("rst_unr", underrun, 1'b0);
        chk("rst_satcnt", sat_cnt, 4'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #2 chk("rel_hold_ready", din_ready, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rel_ready", din_ready, 1'b1);
        chk("rel_satcnt", sat_cnt, 4'd1);

        // 2: stream two pairs, then underrun
        push(8'hA5, 8'h3C);
        push(8'h01, 8'h80);
        chk("s_fill", fill, 4'd2);
        enable = 1'b1;
        phase("s_w0", 8'hA5, 8'h3C, 1'b0);
        phase("s_w1", 8'h01, 8'h80, 1'b0);
        phase("s_ur0", 8'h00, 8'h00, 1'b1);
        phase("s_ur1", 8'h00, 8'h00, 1'b1);
        chk("s_cnt", underrun_cnt, 16'd2);
        enable = 1'b0;
        phase("s_off", 8'h00, 8'h00, 1'b0);
        chk("s_cnt_hold", underrun_cnt, 16'd2);

        // 3: fill to DEPTH, reject extra, drain in order
        for (int i = 0; i < 8; i++) begin
            w = 8'(i * 17 + 3);
            push(w, ~w);
        end
        chk("f_fill", fill, 4'd8);
        chk("f_ready", din_ready, 1'b0);
        push(8'hEE, 8'hEE);
        chk("f_fill_extra", fill, 4'd8);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 8'(i * 17 + 3);
            phase($sformatf("f_w%0d", i), w, ~w, 1'b0);
        end
        phase("f_ur", 8'h00, 8'h00, 1'b1);
        enable = 1'b0;
        chk("f_cnt", underrun_cnt, 16'd3);
        chk("f_empty", fill, 4'd0);

        // 4: training overrides enable and keeps the FIFO
        push(8'hC1, 8'h1C);
        push(8'hC2, 8'h2C);
        push(8'hC3, 8'h3C);
        train  = 1'b1;
        enable = 1'b1;
        phase("t_0", 8'hFF, 8'h00, 1'b0);
        phase("t_1", 8'hFF, 8'h00, 1'b0);
        phase("t_2", 8'hFF, 8'h00, 1'b0);
        chk("t_fill", fill, 4'd3);
        train = 1'b0;
        phase("t_w0", 8'hC1, 8'h1C, 1'b0);
        phase("t_w1", 8'hC2, 8'h2C, 1'b0);
        phase("t_w2", 8'hC3, 8'h3C, 1'b0);
        phase("t_ur", 8'h00, 8'h00, 1'b1);
        enable = 1'b0;
        chk("t_cnt", underrun_cnt, 16'd4);

        // 5: 4-bit counter on the always-underrunning instance
        chk("sat_cnt", sat_cnt, 4'd15);
        repeat (5) @(posedge clk);
        #2;
        chk("sat_cnt_hold", sat_cnt, 4'd15);
        chk("sat_unr", sat_unr, 1'b1);

        // 6: reset at a negedge with words queued
        push(8'hD1, 8'h5A);
        push(8'hD2, 8'h6B);
        push(8'hD3, 8'h7C);
        push(8'hD4, 8'h8D);
        chk("m_fill", fill, 4'd4);
        enable = 1'b1;
        @(posedge clk);
        #2 chk("m_w0_rise", dout, 8'hD1);
        @(negedge clk);
        #1 chk("m_w0_fall", dout, 8'h5A);
        reset_n = 1'b0;
        #1;
        chk("m_rst_dout", dout, 8'h00);
        chk("m_rst_fill", fill, 4'd0);
        chk("m_rst_ready", din_ready, 1'b0);
        chk("m_rst_cnt", underrun_cnt, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        phase("m_idle0", 8'h00, 8'h00, 1'b1);
        phase("m_idle1", 8'h00, 8'h00, 1'b1);
        chk("m_fill_after", fill, 4'd0);
        chk("m_cnt_after", underrun_cnt, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
